// File: rtl/alu_pkg.sv
// rtl/alu_pkg.sv - opcodes, FSM encoding and opcode check shared by the ALU scheduler
package alu_pkg;

  localparam logic [5:0] OP_ADD = 6'b100000;
  localparam logic [5:0] OP_SUB = 6'b100010;
  localparam logic [5:0] OP_AND = 6'b100100;
  localparam logic [5:0] OP_OR  = 6'b100101;
  localparam logic [5:0] OP_XOR = 6'b100110;
  localparam logic [5:0] OP_NOR = 6'b100111;
  localparam logic [5:0] OP_SRA = 6'b000011;
  localparam logic [5:0] OP_SRL = 6'b000010;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ISSUE = 2'd1,
    ST_RESP  = 2'd2
  } state_t;

  // True for the eight opcodes the shared ALU implements
  function automatic logic is_valid_op(input logic [5:0] op);
    case (op)
      OP_ADD, OP_SUB, OP_AND, OP_OR,
      OP_XOR, OP_NOR, OP_SRA, OP_SRL: is_valid_op = 1'b1;
      default:                        is_valid_op = 1'b0;
    endcase
  endfunction

endpackage

// File: rtl/rr_arbiter.sv
// rtl/rr_arbiter.sv - combinational round-robin pick starting at a pointer
module rr_arbiter #(
  parameter int N_REQ = 4
) (
  input  logic [N_REQ-1:0]         req,
  input  logic [$clog2(N_REQ)-1:0] ptr,
  output logic [N_REQ-1:0]         grant,
  output logic [$clog2(N_REQ)-1:0] grant_idx,
  output logic                     any_req
);

  localparam int IW = $clog2(N_REQ);

  logic found;
  int   idx;

  // Walk from ptr upward with wrap; the first requester seen wins
  always_comb begin
    grant     = '0;
    grant_idx = '0;
    found     = 1'b0;
    idx       = 0;
    for (int i = 0; i < N_REQ; i++) begin
      idx = (int'(ptr) + i) % N_REQ;
      if (!found && req[idx]) begin
        found      = 1'b1;
        grant[idx] = 1'b1;
        grant_idx  = IW'(idx);
      end
    end
  end

  assign any_req = |req;

endmodule

// File: rtl/alu_rr_scheduler.sv
// rtl/alu_rr_scheduler.sv - round-robin sharing of one combinational ALU among requesters
module alu_rr_scheduler
  import alu_pkg::*;
#(
  parameter int NB_DATA = 8,
  parameter int NB_OP   = 6,
  parameter int N_REQ   = 4
) (
  input  logic                       clk,
  input  logic                       i_rst_n,
  input  logic [N_REQ-1:0]           i_req_valid,
  output logic [N_REQ-1:0]           o_req_ready,
  input  logic [N_REQ*NB_DATA-1:0]   i_req_data_a,
  input  logic [N_REQ*NB_DATA-1:0]   i_req_data_b,
  input  logic [N_REQ*NB_OP-1:0]     i_req_op,
  output logic [NB_DATA-1:0]         o_alu_data_a,
  output logic [NB_DATA-1:0]         o_alu_data_b,
  output logic [NB_OP-1:0]           o_alu_op,
  input  logic [NB_DATA-1:0]         i_alu_result,
  output logic [N_REQ-1:0]           o_rsp_valid,
  input  logic [N_REQ-1:0]           i_rsp_ready,
  output logic [NB_DATA-1:0]         o_rsp_data,
  output logic                       o_rsp_err,
  output logic                       o_busy,
  output logic [$clog2(N_REQ)-1:0]   o_grant_id
);

  localparam int IW = $clog2(N_REQ);

  state_t          state;
  logic [IW-1:0]   rr_ptr;
  logic [N_REQ-1:0] arb_grant;
  logic [IW-1:0]   arb_idx;
  logic            arb_any;
  logic [IW-1:0]   ptr_next;

  rr_arbiter #(.N_REQ(N_REQ)) u_arb (
    .req       (i_req_valid),
    .ptr       (rr_ptr),
    .grant     (arb_grant),
    .grant_idx (arb_idx),
    .any_req   (arb_any)
  );

  // Pointer moves to the requester just after the winner so it is served last next round
  assign ptr_next = (arb_idx == IW'(N_REQ - 1)) ? '0 : arb_idx + 1'b1;

  // Ready is offered only while idle, and only to the arbiter's winner
  assign o_req_ready = (state == ST_IDLE) ? arb_grant : '0;

  // Scheduler FSM: accept one request, run it through the ALU, hold the response until taken
  always_ff @(posedge clk) begin
    if (!i_rst_n) begin
      state        <= ST_IDLE;
      rr_ptr       <= '0;
      o_alu_data_a <= '0;
      o_alu_data_b <= '0;
      o_alu_op     <= '0;
      o_rsp_valid  <= '0;
      o_rsp_data   <= '0;
      o_rsp_err    <= 1'b0;
      o_busy       <= 1'b0;
      o_grant_id   <= '0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (arb_any) begin
            o_alu_data_a <= i_req_data_a[int'(arb_idx)*NB_DATA +: NB_DATA];
            o_alu_data_b <= i_req_data_b[int'(arb_idx)*NB_DATA +: NB_DATA];
            o_alu_op     <= i_req_op[int'(arb_idx)*NB_OP +: NB_OP];
            o_grant_id   <= arb_idx;
            rr_ptr       <= ptr_next;
            o_busy       <= 1'b1;
            state        <= ST_ISSUE;
          end
        end
        ST_ISSUE: begin
          // Unsupported opcodes return a zero result flagged by err
          if (is_valid_op(o_alu_op)) begin
            o_rsp_data <= i_alu_result;
            o_rsp_err  <= 1'b0;
          end else begin
            o_rsp_data <= '0;
            o_rsp_err  <= 1'b1;
          end
          o_rsp_valid <= N_REQ'(1) << o_grant_id;
          state       <= ST_RESP;
        end
        ST_RESP: begin
          if (i_rsp_ready[o_grant_id]) begin
            o_rsp_valid <= '0;
            o_busy      <= 1'b0;
            state       <= ST_IDLE;
          end
        end
        default: begin
          state <= ST_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_alu_rr_scheduler.sv
// tb/tb_alu_rr_scheduler.sv - directed bench for the round-robin ALU scheduler
module tb_alu_rr_scheduler;

  localparam int NB_DATA = 8;
  localparam int NB_OP   = 6;
  localparam int N_REQ   = 4;

  logic                     clk = 1'b0;
  logic                     rst_n;
  logic [N_REQ-1:0]         req_valid;
  logic [N_REQ-1:0]         req_ready;
  logic [N_REQ*NB_DATA-1:0] req_a;
  logic [N_REQ*NB_DATA-1:0] req_b;
  logic [N_REQ*NB_OP-1:0]   req_op;
  logic [NB_DATA-1:0]       alu_a;
  logic [NB_DATA-1:0]       alu_b;
  logic [NB_OP-1:0]         alu_op;
  logic [NB_DATA-1:0]       alu_result;
  logic [N_REQ-1:0]         rsp_valid;
  logic [N_REQ-1:0]         rsp_ready;
  logic [NB_DATA-1:0]       rsp_data;
  logic                     rsp_err;
  logic                     busy;
  logic [1:0]               grant_id;

  int n_vec  = 0;
  int n_fail = 0;

  alu_rr_scheduler #(.NB_DATA(NB_DATA), .NB_OP(NB_OP), .N_REQ(N_REQ)) dut (
    .clk          (clk),
    .i_rst_n      (rst_n),
    .i_req_valid  (req_valid),
    .o_req_ready  (req_ready),
    .i_req_data_a (req_a),
    .i_req_data_b (req_b),
    .i_req_op     (req_op),
    .o_alu_data_a (alu_a),
    .o_alu_data_b (alu_b),
    .o_alu_op     (alu_op),
    .i_alu_result (alu_result),
    .o_rsp_valid  (rsp_valid),
    .i_rsp_ready  (rsp_ready),
    .o_rsp_data   (rsp_data),
    .o_rsp_err    (rsp_err),
    .o_busy       (busy),
    .o_grant_id   (grant_id)
  );

  always #5 clk = ~clk;

  // Reference ALU; unknown opcodes return junk the scheduler must suppress
  always_comb begin
    case (alu_op)
      6'b100000: alu_result = alu_a + alu_b;
      6'b100010: alu_result = alu_a - alu_b;
      6'b100100: alu_result = alu_a & alu_b;
      6'b100101: alu_result = alu_a | alu_b;
      6'b100110: alu_result = alu_a ^ alu_b;
      6'b100111: alu_result = ~(alu_a | alu_b);
      6'b000011: alu_result = $signed(alu_a) >>> alu_b[2:0];
      6'b000010: alu_result = alu_a >> alu_b[2:0];
      default:   alu_result = 8'hA5;
    endcase
  end

  typedef struct {
    int         k;
    logic [7:0] a;
    logic [7:0] b;
    logic [5:0] op;
    logic [7:0] exp_data;
    logic       exp_err;
  } vec_t;

  vec_t vecs[6];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic set_req(input int k, input logic [7:0] a, input logic [7:0] b, input logic [5:0] op);
    req_a[k*NB_DATA +: NB_DATA] = a;
    req_b[k*NB_DATA +: NB_DATA] = b;
    req_op[k*NB_OP +: NB_OP]    = op;
  endtask

  // Single-requester transaction, entered and left at a negedge in IDLE
  task automatic do_op(input vec_t v);
    set_req(v.k, v.a, v.b, v.op);
    req_valid = 4'b0001 << v.k;
    #1;
    chk("vec_ready", 32'(req_ready), 32'(4'b0001 << v.k));
    @(negedge clk);
    req_valid = '0;
    chk("vec_issue_busy", 32'(busy), 32'd1);
    chk("vec_issue_rspv", 32'(rsp_valid), 32'd0);
    chk("vec_issue_op", 32'(alu_op), 32'(v.op));
    @(negedge clk);
    chk("vec_rsp_valid", 32'(rsp_valid), 32'(4'b0001 << v.k));
    chk("vec_rsp_data", 32'(rsp_data), 32'(v.exp_data));
    chk("vec_rsp_err", 32'(rsp_err), 32'(v.exp_err));
    chk("vec_grant_id", 32'(grant_id), 32'(v.k));
    @(negedge clk);
    chk("vec_done_busy", 32'(busy), 32'd0);
    chk("vec_done_rspv", 32'(rsp_valid), 32'd0);
  endtask

  // Wait (bounded) at negedges until some ready bit is offered
  task automatic wait_ready();
    int n;
    n = 0;
    #1;
    while (req_ready == '0 && n < 10) begin
      @(negedge clk);
      #1;
      n++;
    end
    if (req_ready == '0) begin
      n_vec++;
      n_fail++;
      $display("FAIL wait_ready: got timeout expected a grant");
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [7:0] rr_data[5];
    int         rr_k[5];

    vecs[0] = '{0, 8'd15,  8'd10, 6'b100000, 8'd25,  1'b0};
    vecs[1] = '{2, 8'hF0,  8'd2,  6'b000011, 8'hFC,  1'b0};
    vecs[2] = '{2, 8'd32,  8'd3,  6'b000010, 8'd4,   1'b0};
    vecs[3] = '{1, 8'd7,   8'd9,  6'b111111, 8'd0,   1'b1};
    vecs[4] = '{1, 8'd1,   8'd1,  6'b100000, 8'd2,   1'b0};
    vecs[5] = '{3, 8'h7F,  8'h01, 6'b100000, 8'h80,  1'b0};

    rr_k    = '{0, 1, 2, 3, 0};
    rr_data = '{8'd20, 8'd8, 8'd12, 8'd4, 8'd20};

    rst_n     = 1'b0;
    req_valid = '0;
    req_a     = '0;
    req_b     = '0;
    req_op    = '0;
    rsp_ready = '1;

    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("rst_ready", 32'(req_ready), 32'd0);
    chk("rst_rspv", 32'(rsp_valid), 32'd0);
    chk("rst_data", 32'(rsp_data), 32'd0);
    chk("rst_err", 32'(rsp_err), 32'd0);
    chk("rst_alu", {8'(alu_a), 8'(alu_b), 8'(alu_op), 8'd0}, 32'd0);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_gid", 32'(grant_id), 32'd0);
    rst_n = 1'b1;
    @(negedge clk);

    for (int i = 0; i < 6; i++) do_op(vecs[i]);

    // All four requesters held valid; pointer sits at 0 after the last grant to 3
    set_req(0, 8'd25, 8'd5,  6'b100010);
    set_req(1, 8'd12, 8'd10, 6'b100100);
    set_req(2, 8'd8,  8'd4,  6'b100101);
    set_req(3, 8'd7,  8'd3,  6'b100110);
    req_valid = 4'b1111;
    for (int g = 0; g < 5; g++) begin
      wait_ready();
      chk("rr_ready", 32'(req_ready), 32'(4'b0001 << rr_k[g]));
      @(negedge clk);
      @(negedge clk);
      chk("rr_rspv", 32'(rsp_valid), 32'(4'b0001 << rr_k[g]));
      chk("rr_data", 32'(rsp_data), 32'(rr_data[g]));
      @(negedge clk);
    end
    req_valid = '0;
    @(negedge clk);

    // Pointer is now 1, so req3 beats req0; stall the response with only ready[3] low
    set_req(3, 8'd9,  8'd5,  6'b100111);
    set_req(0, 8'd20, 8'd22, 6'b100000);
    rsp_ready = 4'b0111;
    req_valid = 4'b1001;
    #1;
    chk("stall_ready", 32'(req_ready), 32'b1000);
    @(negedge clk);
    req_valid = 4'b0001;
    @(negedge clk);
    for (int c = 0; c < 20; c++) begin
      chk("stall_rspv", 32'(rsp_valid), 32'b1000);
      chk("stall_data", 32'(rsp_data), 32'hF2);
      chk("stall_ready0", 32'(req_ready), 32'd0);
      @(negedge clk);
    end
    rsp_ready = 4'b1111;
    @(negedge clk);
    #1;
    chk("release_ready", 32'(req_ready), 32'b0001);
    @(negedge clk);
    req_valid = '0;
    @(negedge clk);
    chk("release_rspv", 32'(rsp_valid), 32'b0001);
    chk("release_data", 32'(rsp_data), 32'd42);
    @(negedge clk);

    // Reset while the request is in ISSUE
    set_req(1, 8'd3, 8'd4, 6'b100000);
    req_valid = 4'b0010;
    #1;
    chk("pre_rst_ready", 32'(req_ready), 32'b0010);
    @(negedge clk);
    req_valid = '0;
    chk("pre_rst_busy", 32'(busy), 32'd1);
    rst_n = 1'b0;
    @(negedge clk);
    chk("mid_rst_rspv", 32'(rsp_valid), 32'd0);
    chk("mid_rst_busy", 32'(busy), 32'd0);
    chk("mid_rst_data", {8'(rsp_data), 7'd0, rsp_err, 16'd0}, 32'd0);
    chk("mid_rst_alu", {8'(alu_a), 8'(alu_b), 8'(alu_op), 8'd0}, 32'd0);
    chk("mid_rst_gid", 32'(grant_id), 32'd0);
    rst_n = 1'b1;
    @(negedge clk);
    chk("post_rst_rspv", 32'(rsp_valid), 32'd0);
    set_req(0, 8'd5,  8'd6,  6'b100000);
    set_req(3, 8'hFF, 8'h0F, 6'b100110);
    req_valid = 4'b1001;
    #1;
    chk("post_rst_ready", 32'(req_ready), 32'b0001);
    @(negedge clk);
    req_valid = 4'b1000;
    @(negedge clk);
    chk("post_rst_rspv0", 32'(rsp_valid), 32'b0001);
    chk("post_rst_data0", 32'(rsp_data), 32'd11);
    @(negedge clk);
    #1;
    chk("post_rst_ready3", 32'(req_ready), 32'b1000);
    @(negedge clk);
    req_valid = '0;
    @(negedge clk);
    chk("post_rst_rspv3", 32'(rsp_valid), 32'b1000);
    chk("post_rst_data3", 32'(rsp_data), 32'hF0);
    @(negedge clk);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
    $finish;
  end

endmodule
